// File: rtl/ray_hit_accumulator_pkg.sv
// Shared types for the ray hit accumulator: HitData record, Q16.16 fixed helpers,
// FSM state enum and accumulator initial value.
package ray_hit_accumulator_pkg;

    typedef logic signed [31:0] fixed_t;

    localparam fixed_t FixedInf = 32'sh7FFF_FFFF;

    typedef struct packed {
        logic        bHit;
        fixed_t      T;
        logic [31:0] PI;
        logic [15:0] U;
        logic [15:0] V;
    } hit_data_t;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDrain,
        StFlush,
        StDone
    } hit_accum_state_e;

    localparam hit_data_t HitAccumInit = '{bHit: 1'b0, T: FixedInf, PI: '0, U: '0, V: '0};

    function automatic logic fixed_lt(input fixed_t a, input fixed_t b);
        return a < b;
    endfunction

    // a is always the lower-index operand, so returning a on ties keeps lowest index.
    function automatic hit_data_t hit_pick(input hit_data_t a, input hit_data_t b,
                                           input logic any_mode);
        if (any_mode) begin
            return a.bHit ? a : b;
        end
        return (b.bHit && (!a.bHit || fixed_lt(b.T, a.T))) ? b : a;
    endfunction

endpackage

// File: rtl/hit_min_tree.sv
// Combinational pairwise reduction of WIDTH hit lanes to one: closest hit, or
// lowest-index hit in any mode. Lanes beyond WIDTH are padded as no-hit.
module hit_min_tree
    import ray_hit_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  hit_data_t [WIDTH-1:0] lanes,
    input  logic                  any_mode,
    output hit_data_t             best
);

    localparam int Levels   = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int PadWidth = 1 << Levels;

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        hit_data_t node [PadWidth >> l];
        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < PadWidth; k++) begin : g_k
                if (k < int'(WIDTH)) begin : g_lane
                    assign node[k] = lanes[k];
                end else begin : g_pad
                    assign node[k] = '0;
                end
            end
        end else begin : g_red
            for (genvar k = 0; k < (PadWidth >> l); k++) begin : g_k
                assign node[k] = hit_pick(g_lvl[l-1].node[2*k], g_lvl[l-1].node[2*k+1],
                                          any_mode);
            end
        end
    end

    assign best = g_lvl[Levels].node[0];

endmodule

// File: rtl/ray_hit_accumulator.sv
// Multi-batch closest-hit / any-hit reducer with early-out for shadow rays.
// Define HIT_ACCUM_STATS_EN to enable the saturating accepted-beat counter.
`ifndef BVH_AABB_TEST_UNIT_SIZE
`define BVH_AABB_TEST_UNIT_SIZE 4
`endif

module ray_hit_accumulator
    import ray_hit_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = `BVH_AABB_TEST_UNIT_SIZE,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  any_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  hit_data_t [WIDTH-1:0] in_hit_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output hit_data_t             out_hit_data,
    output logic                  out_any_hit,
    output logic                  early_out,
    output logic                  busy,
    output logic [CNT_W-1:0]      out_batch_count
);

    hit_accum_state_e state_q, state_d;
    hit_data_t        acc_q, s1_q, batch_best;
    logic             s1_valid_q, any_q, early_q;
    logic             fire, start_acc, merge, any_hit_event;

    hit_min_tree #(
        .WIDTH (WIDTH)
    ) u_min_tree (
        .lanes    (in_hit_data),
        .any_mode (any_q),
        .best     (batch_best)
    );

    assign in_ready  = (state_q == StAccum) || (state_q == StDrain);
    assign fire      = in_valid && in_ready;
    assign start_acc = (state_q == StIdle) && start;

    // Once the accumulator holds a hit in any mode it is frozen.
    assign merge = s1_valid_q && s1_q.bHit &&
                   (any_q ? !acc_q.bHit : fixed_lt(s1_q.T, acc_q.T));
    assign any_hit_event = s1_valid_q && any_q && s1_q.bHit && !acc_q.bHit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StAccum;
            StAccum: begin
                if (fire && in_last)    state_d = StFlush;
                else if (any_hit_event) state_d = StDrain;
            end
            StDrain: if (fire && in_last) state_d = StFlush;
            StFlush: state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            any_q      <= 1'b0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= fire && (state_q == StAccum);
            if (fire) s1_q <= batch_best;
            if (start_acc) begin
                acc_q   <= HitAccumInit;
                any_q   <= any_mode;
                early_q <= 1'b0;
            end else begin
                if (merge) acc_q <= s1_q;
                if (any_hit_event) begin
                    early_q <= 1'b1;
                end else if (state_q == StDone && out_ready) begin
                    early_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign out_hit_data = acc_q;
    assign out_any_hit  = acc_q.bHit;
    assign early_out    = early_q;

`ifdef HIT_ACCUM_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_batch_count = cnt_q;
`else
    assign out_batch_count = '0;
`endif

endmodule

// File: tb/tb_ray_hit_accumulator.sv
// Directed scoreboard bench for ray_hit_accumulator (WIDTH=4, CNT_W=16).
module tb_ray_hit_accumulator;
    import ray_hit_accumulator_pkg::*;

    logic            clk = 1'b0;
    logic            reset, start, any_mode, in_valid, in_last, out_ready;
    logic            in_ready, out_valid, out_any_hit, early_out, busy;
    hit_data_t [3:0] in_hit_data;
    hit_data_t       out_hit_data;
    logic [15:0]     out_batch_count;

    typedef struct {
        hit_data_t   hd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ray_hit_accumulator #(
        .WIDTH (4),
        .CNT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .any_mode        (any_mode),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_hit_data     (in_hit_data),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_hit_data    (out_hit_data),
        .out_any_hit     (out_any_hit),
        .early_out       (early_out),
        .busy            (busy),
        .out_batch_count (out_batch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic fixed_t fx(input int i);
        return fixed_t'(i) <<< 16;
    endfunction

    function automatic hit_data_t mk(input logic hit, input fixed_t t, input logic [31:0] pi);
        return '{bHit: hit, T: t, PI: pi, U: pi[15:0] ^ 16'h5a5a, V: pi[31:16]};
    endfunction

    function automatic logic [15:0] ecnt(input int n);
`ifdef HIT_ACCUM_STATS_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    function automatic hit_data_t acc_init();
        return '{bHit: 1'b0, T: 32'sh7FFF_FFFF, PI: '0, U: '0, V: '0};
    endfunction

    // Monitor: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", out_hit_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", 128'(out_hit_data), 128'(e.hd));
                chk("res_any_hit", 128'(out_any_hit), 128'(e.hd.bHit));
                chk("res_count", 128'(out_batch_count), 128'(e.cnt));
            end
        end
    end

    task automatic push_exp(input hit_data_t hd, input int n);
        exp_t e;
        e.hd  = hd;
        e.cnt = ecnt(n);
        sb.push_back(e);
    endtask

    task automatic do_start(input logic m);
        start    = 1'b1;
        any_mode = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'(1'b1));
        chk("start_in_ready", 128'(in_ready), 128'(1'b1));
    endtask

    task automatic beat(input hit_data_t [3:0] l, input logic last);
        in_valid    = 1'b1;
        in_hit_data = l;
        in_last     = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", 128'(out_valid), 128'(1'b1));
    endtask

    task automatic wait_result();
        wait_valid();
        @(posedge clk);
        #1;
        chk("idle_after_accept", 128'(busy), 128'(1'b0));
        chk("early_out_clear", 128'(early_out), 128'(1'b0));
    endtask

    hit_data_t nh, exp_hd;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        nh          = mk(1'b0, fx(1), 32'h0000_dead);
        reset       = 1'b1;
        start       = 1'b0;
        any_mode    = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        in_hit_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_out_hit_data", 128'(out_hit_data), 128'(0));
        chk("rst_flags", 128'({out_any_hit, early_out, busy}), 128'(0));
        chk("rst_count", 128'(out_batch_count), 128'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Closest, 3 beats; no-hit lanes carry smaller T that must be ignored.
        do_start(1'b0);
        beat({nh, nh, nh, mk(1'b1, fx(5), 32'd10)}, 1'b0);
        beat({mk(1'b1, fx(7), 32'd23), nh, mk(1'b1, fx(2), 32'd21), nh}, 1'b0);
        beat({nh, mk(1'b1, fx(3), 32'd32), nh, nh}, 1'b1);
        push_exp(mk(1'b1, fx(2), 32'd21), 3);
        chk("flush_no_valid", 128'(out_valid), 128'(1'b0));
        @(posedge clk);
        #1;
        chk("valid_after_flush", 128'(out_valid), 128'(1'b1));
        wait_result();

        // Equal T across and within batches: earliest wins.
        do_start(1'b0);
        beat({nh, mk(1'b1, fx(2), 32'd102), mk(1'b1, fx(2), 32'd101), nh}, 1'b0);
        beat({nh, nh, nh, mk(1'b1, fx(2), 32'd110)}, 1'b1);
        push_exp(mk(1'b1, fx(2), 32'd101), 2);
        wait_result();

        // No hits over 4 beats.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) beat({nh, nh, nh, nh}, i == 3);
        push_exp(acc_init(), 4);
        wait_result();

        // Any mode: lane 2 wins over smaller-T lane 3; later hit in beat 2 ignored.
        do_start(1'b1);
        beat({nh, nh, nh, nh}, 1'b0);
        beat({mk(1'b1, fx(1), 32'd203), mk(1'b1, fx(9), 32'd202), nh, nh}, 1'b0);
        chk("early_out_not_yet", 128'(early_out), 128'(1'b0));
        beat({nh, nh, nh, mk(1'b1, 32'sh0000_8000, 32'd220)}, 1'b1);
        chk("early_out_rise", 128'(early_out), 128'(1'b1));
        push_exp(mk(1'b1, fx(9), 32'd202), 3);
        @(posedge clk);
        #1;
        chk("early_out_in_done", 128'(early_out), 128'(1'b1));
        wait_result();

        // Back-pressure: result held, start pulses ignored, including on accept.
        out_ready = 1'b0;
        do_start(1'b0);
        exp_hd = mk(1'b1, fx(4), 32'd77);
        beat({nh, exp_hd, nh, nh}, 1'b1);
        push_exp(exp_hd, 1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("hold_valid", 128'(out_valid), 128'(1'b1));
            chk("hold_data", 128'(out_hit_data), 128'(exp_hd));
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_on_accept_ignored", 128'(busy), 128'(1'b0));

        // Minimum query timing: start s, beat s+1, out_valid s+2.
        do_start(1'b0);
        beat({nh, nh, nh, nh}, 1'b1);
        push_exp(acc_init(), 1);
        chk("min_flush", 128'(out_valid), 128'(1'b0));
        @(posedge clk);
        #1;
        chk("min_valid", 128'(out_valid), 128'(1'b1));
        wait_result();

        // Reset during ACCUM beat 2, then a fresh query.
        do_start(1'b0);
        beat({nh, nh, nh, mk(1'b1, fx(1), 32'd300)}, 1'b0);
        beat({nh, nh, nh, nh}, 1'b0);
        in_valid    = 1'b1;
        in_hit_data = {nh, nh, mk(1'b1, 32'sh0000_4000, 32'd301), nh};
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_hit_data", 128'(out_hit_data), 128'(0));
        chk("mid_rst_flags", 128'({in_ready, out_valid, out_any_hit, early_out, busy}), 128'(0));
        chk("mid_rst_count", 128'(out_batch_count), 128'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_start(1'b0);
        beat({mk(1'b1, fx(6), 32'd401), nh, nh, mk(1'b1, fx(4), 32'd400)}, 1'b1);
        push_exp(mk(1'b1, fx(4), 32'd400), 1);
        wait_result();

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
